// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the button/frame-timing/graphics side and the
// breakout game sequencer. The master side drives the raw inputs and
// observes the game status; the slave side is the sequencer itself.
interface breakout_game_ctrl_if;
    // Inputs to the sequencer
    logic [4:0] btn;          // debounced buttons, nonzero = pressed
    logic       frame_tick;   // one-clk pulse per screen refresh
    logic       hit;          // brick-hit level from graphics
    logic       miss;         // ball-lost level from graphics

    // Outputs from the sequencer
    logic       gra_still;    // 1 = graphics frozen at initial positions
    logic [2:0] game_state;   // 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER, 4 WIN
    logic [1:0] lives;
    logic [3:0] score_d1;     // BCD tens
    logic [3:0] score_d0;     // BCD units
    logic [5:0] bricks_left;
    logic       timer_zero;

    // Environment side: drives stimulus, reads status
    modport master (
        output btn, frame_tick, hit, miss,
        input  gra_still, game_state, lives, score_d1, score_d0,
               bricks_left, timer_zero
    );

    // Sequencer side
    modport slave (
        input  btn, frame_tick, hit, miss,
        output gra_still, game_state, lives, score_d1, score_d0,
               bricks_left, timer_zero
    );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: freezes/releases the playfield graphics and
// keeps lives, BCD score and bricks remaining. All game actions are driven
// by single-cycle rising-edge pulses derived from the hit/miss/button levels,
// so a level held for many clocks acts exactly once.
module breakout_game_ctrl #(
    parameter int unsigned LIVES_INIT   = 3,    // 1..3
    parameter int unsigned NUM_BRICKS   = 48,   // 1..63
    parameter int unsigned DELAY_FRAMES = 120   // 1..255
) (
    input  logic                  clk,
    input  logic                  reset,
    breakout_game_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_NEWGAME = 3'd0,
        S_PLAY    = 3'd1,
        S_NEWBALL = 3'd2,
        S_OVER    = 3'd3,
        S_WIN     = 3'd4
    } state_t;

    localparam logic [1:0] LIVES_LOAD  = 2'(LIVES_INIT);
    localparam logic [5:0] BRICKS_LOAD = 6'(NUM_BRICKS);
    localparam logic [7:0] TIMER_LOAD  = 8'(DELAY_FRAMES);

    // Registered state and counters
    state_t     state_q;
    logic       gra_still_q;
    logic [1:0] lives_q;
    logic [3:0] score_d1_q;
    logic [3:0] score_d0_q;
    logic [5:0] bricks_q;
    logic [7:0] timer_q;

    // Input history for edge detection
    logic       hit_q;
    logic       miss_q;
    logic [4:0] btn_q;

    // Edge pulses and precomputed counter updates
    logic       hit_p;
    logic       miss_p;
    logic       start_p;
    logic [3:0] score_d1_d;
    logic [3:0] score_d0_d;
    logic [5:0] bricks_d;
    logic [1:0] lives_d;
    logic [7:0] timer_d;
    logic       timer_zero;
    logic       last_brick;
    logic       last_life;

    assign hit_p      = bus.hit & ~hit_q;
    assign miss_p     = bus.miss & ~miss_q;
    assign start_p    = (bus.btn != 5'd0) && (btn_q == 5'd0);
    assign timer_zero = (timer_q == 8'd0);
    assign last_brick = (bricks_q == 6'd1);
    // lives of 0 can only appear in PLAY through misconfiguration; treat it
    // like the last life so the game still ends.
    assign last_life  = (lives_q <= 2'd1);

    // Capture last-cycle levels so the pulses fire once per rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            btn_q  <= 5'd0;
        end else begin
            hit_q  <= bus.hit;
            miss_q <= bus.miss;
            btn_q  <= bus.btn;
        end
    end

    // Saturating BCD increment of the score (sticks at 99)
    always_comb begin
        score_d1_d = score_d1_q;
        score_d0_d = score_d0_q;
        if (!(score_d1_q == 4'd9 && score_d0_q == 4'd9)) begin
            if (score_d0_q == 4'd9) begin
                score_d0_d = 4'd0;
                score_d1_d = score_d1_q + 4'd1;
            end else begin
                score_d0_d = score_d0_q + 4'd1;
            end
        end
    end

    // Floored decrements for bricks and lives, and the free-running timer step
    always_comb begin
        bricks_d = (bricks_q == 6'd0) ? 6'd0 : bricks_q - 6'd1;
        lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        timer_d  = timer_q;
        if (bus.frame_tick && !timer_zero) begin
            timer_d = timer_q - 8'd1;
        end
    end

    // Game phase sequencing with counters, delay timer and the freeze flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_NEWGAME;
            gra_still_q <= 1'b1;
            lives_q     <= LIVES_LOAD;
            score_d1_q  <= 4'd0;
            score_d0_q  <= 4'd0;
            bricks_q    <= BRICKS_LOAD;
            timer_q     <= 8'd0;
        end else begin
            // Timer counts down on frame ticks unless a phase entry reloads it
            timer_q <= timer_d;

            case (state_q)
                S_NEWGAME: begin
                    if (start_p) begin
                        state_q     <= S_PLAY;
                        gra_still_q <= 1'b0;
                        lives_q     <= LIVES_LOAD;
                        score_d1_q  <= 4'd0;
                        score_d0_q  <= 4'd0;
                        bricks_q    <= BRICKS_LOAD;
                    end
                end

                S_PLAY: begin
                    // Both counter updates apply even when hit and miss coincide
                    if (hit_p) begin
                        score_d1_q <= score_d1_d;
                        score_d0_q <= score_d0_d;
                        bricks_q   <= bricks_d;
                    end
                    if (miss_p) begin
                        lives_q <= lives_d;
                    end

                    // Clearing the last brick outranks losing the ball
                    if (hit_p && last_brick) begin
                        state_q     <= S_WIN;
                        gra_still_q <= 1'b1;
                        timer_q     <= TIMER_LOAD;
                    end else if (miss_p) begin
                        state_q     <= last_life ? S_OVER : S_NEWBALL;
                        gra_still_q <= 1'b1;
                        timer_q     <= TIMER_LOAD;
                    end
                end

                S_NEWBALL: begin
                    // A press during the hold-off is simply dropped
                    if (timer_zero && start_p) begin
                        state_q     <= S_PLAY;
                        gra_still_q <= 1'b0;
                    end
                end

                S_OVER, S_WIN: begin
                    // Counters are left alone so the final score stays on screen
                    if (timer_zero) begin
                        state_q     <= S_NEWGAME;
                        gra_still_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_NEWGAME;
                    gra_still_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.gra_still   = gra_still_q;
    assign bus.game_state  = state_q;
    assign bus.lives       = lives_q;
    assign bus.score_d1    = score_d1_q;
    assign bus.score_d0    = score_d0_q;
    assign bus.bricks_left = bricks_q;
    assign bus.timer_zero  = timer_zero;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for the breakout game sequencer. Instance A uses the default
// parameters; instance B has two bricks and a short delay to reach WIN quickly.
module tb_breakout_game_ctrl;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   n_chk;
    int   n_bad;

    breakout_game_ctrl_if bus_a ();
    breakout_game_ctrl_if bus_b ();

    breakout_game_ctrl dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    breakout_game_ctrl #(
        .LIVES_INIT   (3),
        .NUM_BRICKS   (2),
        .DELAY_FRAMES (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp)
            $display("check %s got=%0d exp=%0d ok", tag, got, exp);
        else begin
            n_bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.btn = 5'd0; bus_a.frame_tick = 1'b0; bus_a.hit = 1'b0; bus_a.miss = 1'b0;
        bus_b.btn = 5'd0; bus_b.frame_tick = 1'b0; bus_b.hit = 1'b0; bus_b.miss = 1'b0;

        // Reset values
        tick();
        check("rst_state",  bus_a.game_state, 0);
        check("rst_still",  bus_a.gra_still, 1);
        check("rst_lives",  bus_a.lives, 3);
        check("rst_d1",     bus_a.score_d1, 0);
        check("rst_d0",     bus_a.score_d0, 0);
        check("rst_bricks", bus_a.bricks_left, 48);
        check("rst_tz",     bus_a.timer_zero, 1);
        reset_a = 1'b0;

        // Start a game: held button counts once, PLAY one clk after the edge
        bus_a.btn = 5'h01;
        tick();
        check("start_state", bus_a.game_state, 1);
        check("start_still", bus_a.gra_still, 0);
        tick();
        tick();
        bus_a.btn = 5'h00;
        check("start_lives",  bus_a.lives, 3);
        check("start_bricks", bus_a.bricks_left, 48);

        // Twelve hits, each held five clocks
        for (int i = 0; i < 12; i++) begin
            bus_a.hit = 1'b1;
            repeat (5) tick();
            if (i == 0) check("hit_held_once", bus_a.score_d0, 1);
            bus_a.hit = 1'b0;
            tick();
        end
        check("hits_d1",     bus_a.score_d1, 1);
        check("hits_d0",     bus_a.score_d0, 2);
        check("hits_bricks", bus_a.bricks_left, 36);

        // Miss -> NEWBALL; early press ignored, press after hold-off resumes
        bus_a.miss = 1'b1;
        tick();
        check("miss1_state", bus_a.game_state, 2);
        check("miss1_lives", bus_a.lives, 2);
        check("miss1_still", bus_a.gra_still, 1);
        check("miss1_tz",    bus_a.timer_zero, 0);
        bus_a.miss = 1'b0;
        tick();
        bus_a.frame_tick = 1'b1;
        repeat (10) tick();
        bus_a.frame_tick = 1'b0;
        bus_a.btn = 5'h02;
        tick();
        check("early_btn_state", bus_a.game_state, 2);
        bus_a.btn = 5'h00;
        tick();
        bus_a.frame_tick = 1'b1;
        repeat (109) tick();
        check("timer_one_tz", bus_a.timer_zero, 0);
        tick();
        check("timer_end_tz", bus_a.timer_zero, 1);
        bus_a.frame_tick = 1'b0;
        bus_a.btn = 5'h10;
        tick();
        check("resume_state", bus_a.game_state, 1);
        check("resume_still", bus_a.gra_still, 0);
        bus_a.btn = 5'h00;
        tick();

        // Second miss, resume, third miss -> OVER
        bus_a.miss = 1'b1;
        tick();
        bus_a.miss = 1'b0;
        check("miss2_lives", bus_a.lives, 1);
        bus_a.frame_tick = 1'b1;
        repeat (120) tick();
        bus_a.frame_tick = 1'b0;
        bus_a.btn = 5'h01;
        tick();
        check("resume2_state", bus_a.game_state, 1);
        bus_a.btn = 5'h00;
        tick();
        bus_a.miss = 1'b1;
        tick();
        bus_a.miss = 1'b0;
        check("over_state", bus_a.game_state, 3);
        check("over_lives", bus_a.lives, 0);
        check("over_still", bus_a.gra_still, 1);
        bus_a.frame_tick = 1'b1;
        repeat (120) tick();
        bus_a.frame_tick = 1'b0;
        check("over_hold_state", bus_a.game_state, 3);
        check("over_tz", bus_a.timer_zero, 1);
        tick();
        check("newgame_state", bus_a.game_state, 0);
        check("kept_d1", bus_a.score_d1, 1);
        check("kept_d0", bus_a.score_d0, 2);

        // Hit outside PLAY is ignored
        bus_a.hit = 1'b1;
        tick();
        bus_a.hit = 1'b0;
        tick();
        check("idle_hit_d0",     bus_a.score_d0, 2);
        check("idle_hit_bricks", bus_a.bricks_left, 36);

        // New game reloads counters
        bus_a.btn = 5'h04;
        tick();
        check("ng_state",  bus_a.game_state, 1);
        check("ng_d1",     bus_a.score_d1, 0);
        check("ng_d0",     bus_a.score_d0, 0);
        check("ng_lives",  bus_a.lives, 3);
        check("ng_bricks", bus_a.bricks_left, 48);
        bus_a.btn = 5'h00;
        tick();

        // Asynchronous reset between clock edges mid-PLAY
        bus_a.hit = 1'b1;
        tick();
        bus_a.hit = 1'b0;
        check("pre_rst_d0", bus_a.score_d0, 1);
        bus_a.btn = 5'h01;
        #3;
        reset_a = 1'b1;
        #1;
        check("arst_state",  bus_a.game_state, 0);
        check("arst_still",  bus_a.gra_still, 1);
        check("arst_d0",     bus_a.score_d0, 0);
        check("arst_bricks", bus_a.bricks_left, 47 + 1);
        check("arst_tz",     bus_a.timer_zero, 1);
        #2;
        reset_a = 1'b0;
        tick();
        check("held_btn_start", bus_a.game_state, 1);
        bus_a.btn = 5'h00;
        tick();

        // Instance B: two bricks -> WIN
        reset_b = 1'b0;
        tick();
        bus_b.btn = 5'h01;
        tick();
        bus_b.btn = 5'h00;
        check("b_start_state",  bus_b.game_state, 1);
        check("b_start_bricks", bus_b.bricks_left, 2);
        bus_b.hit = 1'b1;
        tick();
        bus_b.hit = 1'b0;
        check("b_hit1_bricks", bus_b.bricks_left, 1);
        tick();
        bus_b.hit = 1'b1;
        tick();
        bus_b.hit = 1'b0;
        check("b_win_state",  bus_b.game_state, 4);
        check("b_win_bricks", bus_b.bricks_left, 0);
        check("b_win_d0",     bus_b.score_d0, 2);
        check("b_win_still",  bus_b.gra_still, 1);
        bus_b.frame_tick = 1'b1;
        repeat (4) tick();
        bus_b.frame_tick = 1'b0;
        check("b_win_hold", bus_b.game_state, 4);
        tick();
        check("b_win_exit", bus_b.game_state, 0);

        // Hit and miss together on the last brick: WIN wins, life still lost
        bus_b.btn = 5'h08;
        tick();
        bus_b.btn = 5'h00;
        check("b_ng_bricks", bus_b.bricks_left, 2);
        tick();
        bus_b.hit = 1'b1;
        tick();
        bus_b.hit = 1'b0;
        tick();
        bus_b.hit = 1'b1;
        bus_b.miss = 1'b1;
        tick();
        bus_b.hit = 1'b0;
        bus_b.miss = 1'b0;
        check("b_both_state",  bus_b.game_state, 4);
        check("b_both_lives",  bus_b.lives, 2);
        check("b_both_bricks", bus_b.bricks_left, 0);
        check("b_both_d0",     bus_b.score_d0, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
- Top-level game sequencer for the breakout playfield.
- Decides when the playfield graphics are frozen (gra_still), and tracks lives, score and bricks remaining.
- Walks the game through new-game, play, new-ball, game-over and win phases.
- Sits between the button/frame-timing logic and the playfield graphics block; its counters feed the text/score overlay.

Parameters:
- LIVES_INIT, 3, lives loaded at new game (1..3).
- NUM_BRICKS, 48, bricks per level (1..63).
- DELAY_FRAMES, 120, frame ticks held in NEWBALL/OVER/WIN before exit is permitted (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- btn  in  5  raw debounced buttons; any nonzero value counts as "pressed"
- frame_tick  in  1  one-clk pulse per screen refresh (60 Hz)
- hit  in  1  brick-hit flag from the graphics block; level, may stay high several clks
- miss  in  1  ball-lost flag from the graphics block; level
- gra_still  out  1  1 = graphics frozen at initial positions
- game_state  out  3  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER, 4 WIN
- lives  out  2  remaining lives
- score_d1  out  4  BCD tens digit
- score_d0  out  4  BCD units digit
- bricks_left  out  6  bricks not yet destroyed
- timer_zero  out  1  1 when the delay timer is 0

Behaviour:
- Reset values:
  - state NEWGAME, gra_still 1, lives LIVES_INIT, score 00, bricks_left NUM_BRICKS.
  - timer 0 (timer_zero 1); hit/miss/btn history registers 0.
- Edge detection:
  - hit_p = hit & ~hit_q; miss_p = miss & ~miss_q; start_p = (btn!=0) & (btn_q==0). The _q signals are registered each clk.
  - All counter and state actions use only these pulses. A level held N cycles counts once.
- Timer:
  - 8-bit down-counter, loaded with DELAY_FRAMES on entry to NEWBALL, OVER or WIN.
  - Decrements by 1 on frame_tick when nonzero; holds at 0.
  - timer_zero = (timer==0), combinational from the register.
- gra_still = 1 in every state except PLAY. It is a registered output that changes in the same clk edge as the state.
- NEWGAME:
  - start_p -> PLAY.
  - On the same edge load lives=LIVES_INIT, score=00, bricks_left=NUM_BRICKS.
- PLAY:
  - hit_p:
    - score += 1 in BCD. d0 wraps 9->0 and carries into d1. Score saturates at 99.
    - bricks_left -= 1, floored at 0.
    - If bricks_left==1 before the decrement -> WIN and load timer.
  - miss_p:
    - lives -= 1.
    - If lives==1 before the decrement -> OVER (lives 0), otherwise -> NEWBALL.
    - Load timer in either case.
  - hit_p and miss_p in the same clk: both counter updates apply. WIN takes priority over OVER/NEWBALL.
  - btn ignored.
- NEWBALL: timer_zero & start_p -> PLAY. start_p while the timer is nonzero is ignored.
- OVER and WIN: timer_zero -> NEWGAME. No button needed; counters hold, so the score remains displayed.
- hit_p/miss_p outside PLAY: ignored. No counter changes.
- Undefined state codes 5..7: recover to NEWGAME on the next clk.
- Reset asserted mid-game: all registers return to reset values immediately (async). After release, the first clk samples the _q history as 0. A button already held at release therefore produces start_p on the first clk.
- Latency: every output updates on the clk edge that samples the causing pulse. This is 1 clk after the raw input rises, because of the edge detector.

Test Plan:
- Reset, then btn=5'h01 for 3 clks -> state 1, gra_still 0 one clk after the edge; lives 3, score 00, bricks_left 48.
- In PLAY, hit held high 5 clks, then low; repeat 12 times -> score_d1=1, score_d0=2, bricks_left 36.
- In PLAY, miss pulse -> state 2, lives 2, gra_still 1. btn pressed after 10 frame_ticks -> stays 2. After 120 frame_ticks, btn press -> state 1.
- Three misses from lives 3 -> state 3, lives 0. After 120 frame_ticks -> state 0 with score retained; next btn -> score 00, lives 3.
- NUM_BRICKS=2 instance: two hits -> state 4, bricks_left 0. A hit and a miss in the same clk on the last brick -> state 4, lives decremented.
- Assert reset asynchronously mid-PLAY between clk edges -> outputs return to reset values without waiting for a clk edge.
